// File: rtl/range_frame_sender.sv
// Buffers host samples and replays them as one go/finish framed burst toward a range finder.
// Optional RFS_EXPECT_EN adds exp_range/exp_valid, the range the receiver should report.
module range_frame_sender #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int GAP   = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       send,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       ovf,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           data_out,
   output logic                       go,
   output logic                       finish
`ifdef RFS_EXPECT_EN
   ,
   output logic [WIDTH-1:0]           exp_range,
   output logic                       exp_valid
`endif
);

   // state   | meaning
   // S_IDLE  | accepting writes, waiting for send
   // S_FIRST | first beat on data_out, go high
   // S_MID   | interior beats s1..s(N-2)
   // S_LAST  | final beat, finish high
   // S_GAP   | quiet cycles for the receiver; done on the last one
   typedef enum logic [2:0] {S_IDLE, S_FIRST, S_MID, S_LAST, S_GAP} state_t;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    rem;
   logic [GW-1:0]    gap_cnt;
   logic             send_ok;
   logic             mem_we;

   assign send_ok = (state == S_IDLE) && send && (count != '0);
   assign mem_we  = (state == S_IDLE) && wr_en && !full && !send_ok;

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rem      <= '0;
         gap_cnt  <= '0;
         count    <= '0;
         full     <= 1'b0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         go       <= 1'b0;
         finish   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (send_ok) begin
                  state    <= S_FIRST;
                  busy     <= 1'b1;
                  go       <= 1'b1;
                  data_out <= mem[rd_ptr];
                  rd_ptr   <= rd_ptr + 1'b1;
                  rem      <= count - 1'b1;
                  ovf      <= wr_en;
               end else if (wr_en) begin
                  if (full) begin
                     ovf <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                     count  <= count + 1'b1;
                     full   <= (count == CW'(DEPTH - 1));
                  end
               end
            end
            S_FIRST, S_MID: begin
               go <= 1'b0;
               // rem==0 only for a single-sample frame: data_out holds s0 for the closing beat
               if (rem == '0) begin
                  state  <= S_LAST;
                  finish <= 1'b1;
               end else begin
                  data_out <= mem[rd_ptr];
                  rd_ptr   <= rd_ptr + 1'b1;
                  rem      <= rem - 1'b1;
                  if (rem == CW'(1)) begin
                     state  <= S_LAST;
                     finish <= 1'b1;
                  end else begin
                     state <= S_MID;
                  end
               end
            end
            S_LAST: begin
               state    <= S_GAP;
               finish   <= 1'b0;
               data_out <= '0;
               gap_cnt  <= GW'(GAP - 1);
               done     <= (GAP == 1);
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state  <= S_IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b0;
                  count  <= '0;
                  full   <= 1'b0;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
                  done    <= (gap_cnt == GW'(1));
               end
            end
            default: state <= S_IDLE;
         endcase
         if (state != S_IDLE && wr_en) ovf <= 1'b1;
      end
   end

`ifdef RFS_EXPECT_EN
   logic [WIDTH-1:0] trk_max;
   logic [WIDTH-1:0] trk_min;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trk_max   <= '0;
         trk_min   <= '0;
         exp_range <= '0;
         exp_valid <= 1'b0;
      end else begin
         exp_valid <= (state == S_LAST);
         if (state == S_LAST) exp_range <= trk_max - trk_min;
         if (send_ok) begin
            trk_max   <= mem[rd_ptr];
            trk_min   <= mem[rd_ptr];
            exp_range <= '0;
         end else if ((state == S_FIRST || state == S_MID) && rem != '0) begin
            if (mem[rd_ptr] > trk_max) trk_max <= mem[rd_ptr];
            if (mem[rd_ptr] < trk_min) trk_min <= mem[rd_ptr];
         end
      end
   end
`endif

endmodule
